// File: rtl/cmn_stream_pkg.sv
// Shared types for the cmn_stream blocks.
// Holds the one-entry slot state and the select-width helper.
package cmn_stream_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    // Width of a select field addressing n channels (never zero).
    function automatic int CMN_SEL_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cmn_stream_demux_slot.sv
// One-entry val/rdy output buffer used per demux channel.
// Ports: clk/reset, load+msg_in (fill), free (can take a load now),
//        send_val/send_rdy/send_msg (consumer side).
module cmn_stream_demux_slot
    import cmn_stream_pkg::*;
#(
    parameter int nbits = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [nbits-1:0] msg_in,
    output logic             free,
    output logic             send_val,
    input  logic             send_rdy,
    output logic [nbits-1:0] send_msg
);

    slot_state_e      state_q, state_d;
    logic [nbits-1:0] msg_q, msg_d;

    // Kept apart from the next-state logic: free feeds the top-level
    // load decision, which in turn feeds back into this slot.
    assign free     = (state_q == EMPTY) || send_rdy;
    assign send_val = (state_q == FULL);
    assign send_msg = msg_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            msg_q   <= '0;
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        msg_d   = msg_q;
        unique case (state_q)
            EMPTY: begin
                if (load) begin
                    state_d = FULL;
                    msg_d   = msg_in;
                end
            end
            FULL: begin
                // Drain plus load keeps the slot full with the new
                // message, so the output sees no bubble.
                if (load) begin
                    msg_d = msg_in;
                end else if (send_rdy) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

endmodule

// File: rtl/cmn_stream_demux.sv
// Registered 1-to-N val/rdy demux with per-output one-entry buffers.
// Ports: recv_* (producer, sel/bcast steering), send_* (N consumers),
//        err_sel (sticky out-of-range select flag).
module cmn_stream_demux
    import cmn_stream_pkg::*;
#(
    parameter int nbits    = 32,
    parameter int noutputs = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  recv_val,
    output logic                                  recv_rdy,
    input  logic [nbits-1:0]                      recv_msg,
    input  logic [CMN_SEL_W(noutputs)-1:0]        recv_sel,
    input  logic                                  recv_bcast,
    output logic [noutputs-1:0]                   send_val,
    input  logic [noutputs-1:0]                   send_rdy,
    output logic [nbits-1:0]                      send_msg [0:noutputs-1],
    output logic                                  err_sel
);

    localparam int SW = CMN_SEL_W(noutputs);

    logic [noutputs-1:0] hit;
    logic [noutputs-1:0] tgt;
    logic [noutputs-1:0] free;
    logic [noutputs-1:0] load;
    logic                oor;
    logic                recv_fire;
    logic                err_sel_q, err_sel_d;

    always_comb begin
        hit = '0;
        for (int i = 0; i < noutputs; i++) begin
            hit[i] = (recv_sel == SW'(i));
        end
    end

    // No channel matches only when sel is past the last output.
    assign oor       = ~|hit;
    assign tgt       = recv_bcast ? {noutputs{1'b1}} : hit;
    assign recv_rdy  = !reset && (&(~tgt | free));
    assign recv_fire = recv_val && recv_rdy;
    assign load      = recv_fire ? tgt : '0;
    assign err_sel_d = err_sel_q | (recv_fire & ~recv_bcast & oor);
    assign err_sel   = err_sel_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_sel_q <= 1'b0;
        end else begin
            err_sel_q <= err_sel_d;
        end
    end

    for (genvar g = 0; g < noutputs; g++) begin : g_slot
        cmn_stream_demux_slot #(
            .nbits (nbits)
        ) u_slot (
            .clk      (clk),
            .reset    (reset),
            .load     (load[g]),
            .msg_in   (recv_msg),
            .free     (free[g]),
            .send_val (send_val[g]),
            .send_rdy (send_rdy[g]),
            .send_msg (send_msg[g])
        );
    end

endmodule

// File: tb/tb_cmn_stream_demux.sv
// Directed and scoreboarded checks for cmn_stream_demux.
// Covers a 4-output instance and a 3-output instance for bad selects.
module tb_cmn_stream_demux;

    logic        clk = 1'b0;
    logic        reset;

    logic        r_val, r_rdy, bc;
    logic [31:0] msg;
    logic [1:0]  sel;
    logic [3:0]  s_val, s_rdy;
    logic [31:0] s_msg [0:3];
    logic        err;

    logic        r_val3, r_rdy3, bc3;
    logic [31:0] msg3;
    logic [1:0]  sel3;
    logic [2:0]  s_val3, s_rdy3;
    logic [31:0] s_msg3 [0:2];
    logic        err3;

    int nvec = 0;
    int nerr = 0;

    logic [31:0] sb [4][$];

    always #5 clk = ~clk;

    cmn_stream_demux #(.nbits(32), .noutputs(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .recv_val   (r_val),
        .recv_rdy   (r_rdy),
        .recv_msg   (msg),
        .recv_sel   (sel),
        .recv_bcast (bc),
        .send_val   (s_val),
        .send_rdy   (s_rdy),
        .send_msg   (s_msg),
        .err_sel    (err)
    );

    cmn_stream_demux #(.nbits(32), .noutputs(3)) dut3 (
        .clk        (clk),
        .reset      (reset),
        .recv_val   (r_val3),
        .recv_rdy   (r_rdy3),
        .recv_msg   (msg3),
        .recv_sel   (sel3),
        .recv_bcast (bc3),
        .send_val   (s_val3),
        .send_rdy   (s_rdy3),
        .send_msg   (s_msg3),
        .err_sel    (err3)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] s, input logic [31:0] m,
                        input logic b);
        r_val = 1'b1;
        sel   = s;
        msg   = m;
        bc    = b;
    endtask

    initial begin
        reset  = 1'b1;
        r_val  = 1'b0; msg  = '0; sel  = '0; bc  = 1'b0; s_rdy  = '0;
        r_val3 = 1'b0; msg3 = '0; sel3 = '0; bc3 = 1'b0; s_rdy3 = '0;
        step();
        step();
        chk("rst_rdy", r_rdy, 1'b0);
        chk("rst_val", s_val, 4'b0000);
        chk("rst_msg0", s_msg[0], 32'h0);
        chk("rst_err", err, 1'b0);
        chk("rst_err3", err3, 1'b0);
        reset = 1'b0;
        #1;

        // unicast sweep
        s_rdy = 4'hF;
        for (int i = 0; i < 4; i++) begin
            send(2'(i), 32'hA0 + 32'(i), 1'b0);
            #1;
            chk("uni_rdy", r_rdy, 1'b1);
            step();
            chk("uni_val", s_val[i], 1'b1);
            chk("uni_msg", s_msg[i], 32'hA0 + 32'(i));
        end
        r_val = 1'b0;
        chk("uni_last", s_val, 4'b1000);
        step();
        chk("uni_drain", s_val, 4'b0000);

        // backpressure on output 2
        s_rdy = 4'b1011;
        send(2'd2, 32'h11, 1'b0);
        #1;
        chk("bp_rdy0", r_rdy, 1'b1);
        step();
        chk("bp_msg11", s_msg[2], 32'h11);
        send(2'd2, 32'h22, 1'b0);
        #1;
        chk("bp_stall", r_rdy, 1'b0);
        step();
        chk("bp_hold", s_msg[2], 32'h11);
        chk("bp_holdv", s_val, 4'b0100);
        send(2'd1, 32'h33, 1'b0);
        #1;
        chk("bp_other", r_rdy, 1'b1);
        step();
        chk("bp_msg33", s_msg[1], 32'h33);
        chk("bp_val", s_val, 4'b0110);
        send(2'd2, 32'h22, 1'b0);
        s_rdy = 4'hF;
        #1;
        chk("bp_release", r_rdy, 1'b1);
        step();
        chk("bp_nobub_v", s_val, 4'b0100);
        chk("bp_msg22", s_msg[2], 32'h22);
        r_val = 1'b0;
        step();
        chk("bp_empty", s_val, 4'b0000);

        // broadcast blocked by full slot 2
        s_rdy = 4'b1011;
        send(2'd2, 32'h44, 1'b0);
        step();
        send(2'd0, 32'h55, 1'b1);
        #1;
        chk("bc_block", r_rdy, 1'b0);
        step();
        chk("bc_noload", s_val, 4'b0100);
        chk("bc_keep44", s_msg[2], 32'h44);
        s_rdy = 4'hF;
        #1;
        chk("bc_rdy", r_rdy, 1'b1);
        step();
        r_val = 1'b0;
        bc    = 1'b0;
        chk("bc_val", s_val, 4'b1111);
        chk("bc_msg0", s_msg[0], 32'h55);
        chk("bc_msg2", s_msg[2], 32'h55);
        chk("bc_msg3", s_msg[3], 32'h55);
        step();

        // out-of-range select on 3-output instance
        s_rdy3 = 3'b111;
        r_val3 = 1'b1;
        sel3   = 2'd3;
        msg3   = 32'h77;
        #1;
        chk("oor_rdy", r_rdy3, 1'b1);
        step();
        chk("oor_noval", s_val3, 3'b000);
        chk("oor_err", err3, 1'b1);
        sel3 = 2'd0;
        msg3 = 32'h78;
        step();
        r_val3 = 1'b0;
        chk("oor_next", s_val3, 3'b001);
        chk("oor_msg", s_msg3[0], 32'h78);
        chk("oor_sticky", err3, 1'b1);
        chk("oor_err4", err, 1'b0);
        step();
        chk("oor_sticky2", err3, 1'b1);

        // reset mid-operation
        s_rdy = 4'b0000;
        send(2'd0, 32'h66, 1'b0);
        step();
        send(2'd1, 32'h67, 1'b0);
        step();
        r_val = 1'b0;
        chk("mr_fill", s_val, 4'b0011);
        reset = 1'b1;
        #1;
        chk("mr_rdy", r_rdy, 1'b0);
        step();
        reset = 1'b0;
        chk("mr_val", s_val, 4'b0000);
        chk("mr_msg0", s_msg[0], 32'h0);
        chk("mr_msg1", s_msg[1], 32'h0);
        chk("mr_err3", err3, 1'b0);
        s_rdy = 4'hF;
        send(2'd3, 32'h99, 1'b0);
        step();
        r_val = 1'b0;
        chk("mr_after_v", s_val, 4'b1000);
        chk("mr_after_m", s_msg[3], 32'h99);
        step();

        // random stress against per-output scoreboard
        for (int c = 0; c < 10000; c++) begin
            logic [3:0] tg;
            logic       er;
            r_val = ($urandom_range(3) != 0);
            bc    = ($urandom_range(7) == 0);
            sel   = 2'($urandom_range(3));
            msg   = $urandom;
            s_rdy = 4'($urandom);
            #1;
            tg = bc ? 4'hF : (4'b0001 << sel);
            er = 1'b1;
            for (int i = 0; i < 4; i++) begin
                chk("rs_val", s_val[i], sb[i].size() != 0);
                if (sb[i].size() != 0)
                    chk("rs_msg", s_msg[i], sb[i][0]);
                if (tg[i] && sb[i].size() != 0 && !s_rdy[i])
                    er = 1'b0;
            end
            chk("rs_rdy", r_rdy, er);
            for (int i = 0; i < 4; i++) begin
                if (sb[i].size() != 0 && s_rdy[i])
                    void'(sb[i].pop_front());
                if (r_val && er && tg[i])
                    sb[i].push_back(msg);
            end
            step();
        end
        r_val = 1'b0;
        s_rdy = 4'hF;
        step();
        chk("rs_final", s_val, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
